// File: rtl/conv_layer_sequencer.sv
// -----------------------------------------------------------------------------
// conv_layer_sequencer
//
// Drives one QuantizedConvReLU2d instance through a complete layer pass:
// streams weights and biases (optionally), then the padded input map, into the
// conv block's write ports. It then pulses conv_start and collects conv results
// into a first-word-fall-through FIFO that feeds the next layer.
//
// Ports
//   clk, rstn                        clock, asynchronous active-low reset
//   cfg_start, cfg_reload            pass request; reload=1 also loads weights/biases
//   s_data/s_valid/s_ready           byte stream: weights, then input map
//   s_bias/s_bias_valid/s_bias_ready 32-bit bias stream
//   conv_start                       one-cycle start pulse to the conv block
//   input_data_*/weight_data_*/bias_data_*   registered conv RAM write ports
//   conv_done/conv_valid/conv_result conv status and unthrottled results
//   m_data/m_valid/m_ready/m_last    result stream (m_last marks the final result)
//   busy, layer_done, overflow       pass status; overflow is sticky until next start
//
// State table
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for cfg_start
//   S_LOAD_W  | accepting W_SIZE weight bytes from s_*
//   S_LOAD_B  | accepting OUTPUT_CHANNELS bias words from s_bias_*
//   S_LOAD_IN | accepting IN_SIZE input bytes from s_*
//   S_KICK    | waiting for conv_done low, then issuing conv_start
//   S_RUN     | collecting results until all counted and conv_done seen
//   S_DRAIN   | waiting for the result FIFO to empty
//   S_FINISH  | one-cycle layer_done, busy low
// -----------------------------------------------------------------------------
module conv_layer_sequencer #(
    parameter int INPUT_CHANNELS  = 1,
    parameter int OUTPUT_CHANNELS = 32,
    parameter int KERNEL_SIZE     = 3,
    parameter int INPUT_WIDTH     = 30,
    parameter int INPUT_HEIGHT    = 30,
    parameter int FIFO_DEPTH      = 16,
    localparam int IN_SIZE   = INPUT_CHANNELS * INPUT_HEIGHT * INPUT_WIDTH,
    localparam int W_SIZE    = OUTPUT_CHANNELS * INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int OUT_COUNT = OUTPUT_CHANNELS * (INPUT_HEIGHT - KERNEL_SIZE + 1)
                               * (INPUT_WIDTH - KERNEL_SIZE + 1),
    localparam int IN_AW     = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
    localparam int W_AW      = (W_SIZE > 1) ? $clog2(W_SIZE) : 1,
    localparam int B_AW      = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rstn,

    input  logic             cfg_start,
    input  logic             cfg_reload,

    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,

    input  logic [31:0]      s_bias,
    input  logic             s_bias_valid,
    output logic             s_bias_ready,

    output logic             conv_start,
    output logic [7:0]       input_data_in,
    output logic             input_data_we,
    output logic [IN_AW-1:0] input_data_addr,
    output logic [7:0]       weight_data_in,
    output logic             weight_data_we,
    output logic [W_AW-1:0]  weight_data_addr,
    output logic [31:0]      bias_data_in,
    output logic             bias_data_we,
    output logic [B_AW-1:0]  bias_data_addr,

    input  logic             conv_done,
    input  logic             conv_valid,
    input  logic [7:0]       conv_result,

    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,

    output logic             busy,
    output logic             layer_done,
    output logic             overflow
);

    localparam int RES_W = $clog2(OUT_COUNT + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [W_AW-1:0]  W_LAST   = W_AW'(W_SIZE - 1);
    localparam logic [B_AW-1:0]  B_LAST   = B_AW'(OUTPUT_CHANNELS - 1);
    localparam logic [IN_AW-1:0] IN_LAST  = IN_AW'(IN_SIZE - 1);
    localparam logic [RES_W-1:0] RES_FULL = RES_W'(OUT_COUNT);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(OUT_COUNT - 1);
    localparam logic [CNT_W-1:0] FIFO_MAX = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_B, S_LOAD_IN, S_KICK, S_RUN, S_DRAIN, S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic [W_AW-1:0]  w_addr_q,  w_addr_d;
    logic [B_AW-1:0]  b_addr_q,  b_addr_d;
    logic [IN_AW-1:0] in_addr_q, in_addr_d;
    logic [RES_W-1:0] res_cnt_q, res_cnt_d;
    logic             done_seen_q, done_seen_d;
    logic             overflow_q, overflow_d;
    logic             conv_start_q, conv_start_d;

    logic             weight_we_q, weight_we_d;
    logic [W_AW-1:0]  weight_addr_q, weight_addr_d;
    logic [7:0]       weight_din_q, weight_din_d;
    logic             bias_we_q, bias_we_d;
    logic [B_AW-1:0]  bias_addr_q, bias_addr_d;
    logic [31:0]      bias_din_q, bias_din_d;
    logic             input_we_q, input_we_d;
    logic [IN_AW-1:0] input_addr_q, input_addr_d;
    logic [7:0]       input_din_q, input_din_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [8:0]       fifo_mem_q [FIFO_DEPTH];

    logic s_ready_c, s_bias_ready_c, busy_c, layer_done_c;
    logic start_acc, s_hs, b_hs;
    logic fifo_empty, fifo_full, fifo_pop, push_req, push_ok, push_drop, res_last;
    logic [8:0] fifo_head;

    assign start_acc  = (state_q == S_IDLE) && cfg_start;
    assign s_hs       = s_valid && s_ready_c;
    assign b_hs       = s_bias_valid && s_bias_ready_c;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FIFO_MAX);
    assign fifo_pop   = !fifo_empty && m_ready;
    assign push_req   = (state_q == S_RUN) && conv_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || fifo_pop);
    assign push_drop  = push_req && fifo_full && !fifo_pop;
    assign res_last   = (res_cnt_q == RES_LAST);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (cfg_start) state_d = cfg_reload ? S_LOAD_W : S_LOAD_IN;
            S_LOAD_W:  if (s_hs && (w_addr_q == W_LAST)) state_d = S_LOAD_B;
            S_LOAD_B:  if (b_hs && (b_addr_q == B_LAST)) state_d = S_LOAD_IN;
            S_LOAD_IN: if (s_hs && (in_addr_q == IN_LAST)) state_d = S_KICK;
            S_KICK:    if (!conv_done) state_d = S_RUN;
            // Result count and conv_done may complete in either order.
            S_RUN:     if ((res_cnt_q == RES_FULL) && (done_seen_q || conv_done)) state_d = S_DRAIN;
            S_DRAIN:   if (fifo_empty) state_d = S_FINISH;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        s_ready_c      = 1'b0;
        s_bias_ready_c = 1'b0;
        busy_c         = 1'b1;
        layer_done_c   = 1'b0;
        unique case (state_q)
            S_IDLE:    busy_c = 1'b0;
            S_LOAD_W:  s_ready_c = 1'b1;
            S_LOAD_B:  s_bias_ready_c = 1'b1;
            S_LOAD_IN: s_ready_c = 1'b1;
            S_FINISH: begin
                busy_c       = 1'b0;
                layer_done_c = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath next values
    always_comb begin
        w_addr_d      = w_addr_q;
        b_addr_d      = b_addr_q;
        in_addr_d     = in_addr_q;
        res_cnt_d     = res_cnt_q;
        done_seen_d   = done_seen_q;
        overflow_d    = overflow_q;
        conv_start_d  = 1'b0;
        weight_we_d   = 1'b0;
        weight_addr_d = weight_addr_q;
        weight_din_d  = weight_din_q;
        bias_we_d     = 1'b0;
        bias_addr_d   = bias_addr_q;
        bias_din_d    = bias_din_q;
        input_we_d    = 1'b0;
        input_addr_d  = input_addr_q;
        input_din_d   = input_din_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;

        if (start_acc) begin
            w_addr_d    = '0;
            b_addr_d    = '0;
            in_addr_d   = '0;
            res_cnt_d   = '0;
            done_seen_d = 1'b0;
            overflow_d  = 1'b0;
        end

        if ((state_q == S_LOAD_W) && s_hs) begin
            weight_we_d   = 1'b1;
            weight_addr_d = w_addr_q;
            weight_din_d  = s_data;
            w_addr_d      = w_addr_q + W_AW'(1);
        end

        if ((state_q == S_LOAD_B) && b_hs) begin
            bias_we_d   = 1'b1;
            bias_addr_d = b_addr_q;
            bias_din_d  = s_bias;
            b_addr_d    = b_addr_q + B_AW'(1);
        end

        if ((state_q == S_LOAD_IN) && s_hs) begin
            input_we_d   = 1'b1;
            input_addr_d = in_addr_q;
            input_din_d  = s_data;
            in_addr_d    = in_addr_q + IN_AW'(1);
        end

        if ((state_q == S_KICK) && !conv_done) begin
            conv_start_d = 1'b1;
        end

        if (state_q == S_RUN) begin
            if (conv_done) begin
                done_seen_d = 1'b1;
            end
            // Saturate so a misbehaving conv block cannot wrap the count.
            if (conv_valid && (res_cnt_q != RES_FULL)) begin
                res_cnt_d = res_cnt_q + RES_W'(1);
            end
        end

        if (push_drop) begin
            overflow_d = 1'b1;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_addr_q      <= '0;
            b_addr_q      <= '0;
            in_addr_q     <= '0;
            res_cnt_q     <= '0;
            done_seen_q   <= 1'b0;
            overflow_q    <= 1'b0;
            conv_start_q  <= 1'b0;
            weight_we_q   <= 1'b0;
            weight_addr_q <= '0;
            weight_din_q  <= '0;
            bias_we_q     <= 1'b0;
            bias_addr_q   <= '0;
            bias_din_q    <= '0;
            input_we_q    <= 1'b0;
            input_addr_q  <= '0;
            input_din_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            w_addr_q      <= w_addr_d;
            b_addr_q      <= b_addr_d;
            in_addr_q     <= in_addr_d;
            res_cnt_q     <= res_cnt_d;
            done_seen_q   <= done_seen_d;
            overflow_q    <= overflow_d;
            conv_start_q  <= conv_start_d;
            weight_we_q   <= weight_we_d;
            weight_addr_q <= weight_addr_d;
            weight_din_q  <= weight_din_d;
            bias_we_q     <= bias_we_d;
            bias_addr_q   <= bias_addr_d;
            bias_din_q    <= bias_din_d;
            input_we_q    <= input_we_d;
            input_addr_q  <= input_addr_d;
            input_din_q   <= input_din_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // FIFO storage needs no reset; the occupancy count alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= {res_last, conv_result};
        end
    end

    assign s_ready          = s_ready_c;
    assign s_bias_ready     = s_bias_ready_c;
    assign busy             = busy_c;
    assign layer_done       = layer_done_c;
    assign overflow         = overflow_q;
    assign conv_start       = conv_start_q;
    assign weight_data_we   = weight_we_q;
    assign weight_data_addr = weight_addr_q;
    assign weight_data_in   = weight_din_q;
    assign bias_data_we     = bias_we_q;
    assign bias_data_addr   = bias_addr_q;
    assign bias_data_in     = bias_din_q;
    assign input_data_we    = input_we_q;
    assign input_data_addr  = input_addr_q;
    assign input_data_in    = input_din_q;
    assign m_valid          = !fifo_empty;
    // Gate the head so stale or never-written entries are not visible when empty.
    assign m_data           = fifo_empty ? 8'h00 : fifo_head[7:0];
    assign m_last           = !fifo_empty && fifo_head[8];

endmodule
